// File: rtl/vga_pkg.sv
// vga_pkg: shared framebuffer widths and scheduler state encodings
package vga_pkg;
  localparam int FB_ADDR_W = 16;
  localparam int PIX_W = 12;
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RD = 2'd1;
  localparam logic [1:0] S_WR = 2'd2;
endpackage

// File: rtl/sync_fifo.sv
// sync_fifo: single-clock FIFO, registered head, no fall-through
module sync_fifo #(
  parameter int WIDTH = 28,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  assign full = level == LW'(DEPTH);
  assign empty = level == '0;
  assign dout = mem[rd_ptr];
  // storage array needs no reset; occupancy decides what is valid
  always_ff @(posedge clk)
    if (push) mem[wr_ptr] <= din;
  // pointers wrap naturally at the power-of-two depth
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level <= '0;
    end else begin
      wr_ptr <= wr_ptr + AW'(push);
      rd_ptr <= rd_ptr + AW'(pop);
      level <= level + LW'(push) - LW'(pop);
    end
endmodule

// File: rtl/vga_fb_arbiter.sv
// vga_fb_arbiter: single-port framebuffer share, scan-out reads over buffered host writes
module vga_fb_arbiter
  import vga_pkg::*;
#(
  parameter int ADDR_W = FB_ADDR_W,
  parameter int DATA_W = PIX_W,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          clk_i,
  input  logic                          rst_n_i,
  input  logic                          disp_req_i,
  input  logic [ADDR_W-1:0]             disp_addr_i,
  output logic                          disp_vld_o,
  output logic [DATA_W-1:0]             disp_data_o,
  input  logic                          host_valid_i,
  input  logic [ADDR_W-1:0]             host_addr_i,
  input  logic [DATA_W-1:0]             host_data_i,
  output logic                          host_ready_o,
  output logic                          mem_en_o,
  output logic                          mem_we_o,
  output logic [ADDR_W-1:0]             mem_addr_o,
  output logic [DATA_W-1:0]             mem_wdata_o,
  input  logic [DATA_W-1:0]             mem_rdata_i,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level_o,
  output logic                          ovf_o
);
  logic [1:0] state, nxt;
  logic full, empty, push, pop;
  logic [ADDR_W+DATA_W-1:0] head;
  logic [2:0] vld_sr;
  assign host_ready_o = !full;
  assign push = host_valid_i && !full;
  assign nxt = disp_req_i ? S_RD : !empty ? S_WR : S_IDLE;
  assign pop = nxt == S_WR;
  assign mem_en_o = state != S_IDLE;
  assign mem_we_o = state == S_WR;
  assign disp_vld_o = vld_sr[2];

  sync_fifo #(.WIDTH(ADDR_W + DATA_W), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk(clk_i),
    .rst_n(rst_n_i),
    .push(push),
    .pop(pop),
    .din({host_addr_i, host_data_i}),
    .dout(head),
    .full(full),
    .empty(empty),
    .level(fifo_level_o)
  );

  // scheduler: register the chosen access; address/data hold while idle
  always_ff @(posedge clk_i or negedge rst_n_i)
    if (!rst_n_i) begin
      state <= S_IDLE;
      mem_addr_o <= '0;
      mem_wdata_o <= '0;
    end else begin
      state <= nxt;
      if (nxt == S_RD) mem_addr_o <= disp_addr_i;
      else if (nxt == S_WR) {mem_addr_o, mem_wdata_o} <= head;
    end
  // read-valid pipeline: capture RAM data on the stage before the strobe
  always_ff @(posedge clk_i or negedge rst_n_i)
    if (!rst_n_i) begin
      vld_sr <= '0;
      disp_data_o <= '0;
    end else begin
      vld_sr <= {vld_sr[1:0], disp_req_i};
      if (vld_sr[1]) disp_data_o <= mem_rdata_i;
    end
  // sticky overflow on any refused host offer
  always_ff @(posedge clk_i or negedge rst_n_i)
    if (!rst_n_i) ovf_o <= 1'b0;
    else if (host_valid_i && full) ovf_o <= 1'b1;
endmodule

// File: doc/vga_fb_arbiter.md
VGA_FB_ARBITER -- requirements
Module: vga_fb_arbiter

Interface
REQ-001 Parameter ADDR_W, default 16, framebuffer word-address width.
REQ-002 Parameter DATA_W, default 12, pixel width (4:4:4 RGB, red in the MSBs).
REQ-003 Parameter FIFO_DEPTH, default 4, host write FIFO entries; power of two, at least 2.
REQ-004 clk_i  in  1  pixel-domain clock (clk_vga); the only clock.
REQ-005 rst_n_i  in  1  asynchronous, active-low reset.
REQ-006 disp_req_i  in  1  scan-out fetch request, one pixel per asserted cycle.
REQ-007 disp_addr_i  in  ADDR_W  scan-out fetch address.
REQ-008 disp_vld_o  out  1  disp_data_o valid strobe.
REQ-009 disp_data_o  out  DATA_W  fetched pixel.
REQ-010 host_valid_i  in  1  host write offered.
REQ-011 host_addr_i  in  ADDR_W  host write address.
REQ-012 host_data_i  in  DATA_W  host write data.
REQ-013 host_ready_o  out  1  host write accepted when high with host_valid_i.
REQ-014 mem_en_o  out  1  RAM port enable.
REQ-015 mem_we_o  out  1  RAM write enable.
REQ-016 mem_addr_o  out  ADDR_W  RAM address.
REQ-017 mem_wdata_o  out  DATA_W  RAM write data.
REQ-018 mem_rdata_i  in  DATA_W  RAM read data, valid one cycle after a read enable.
REQ-019 fifo_level_o  out  clog2(FIFO_DEPTH)+1  host FIFO occupancy.
REQ-020 ovf_o  out  1  sticky flag: host_valid_i was high while host_ready_o was low.

Function
REQ-021 The block shall share one single-port framebuffer RAM between scan-out reads and host writes, with scan-out having strict priority.
REQ-022 Host handshake: a transfer occurs on a cycle with host_valid_i=1 and host_ready_o=1; host_ready_o shall equal (FIFO not full).
REQ-023 An accepted host write shall be pushed into the FIFO in the same cycle.
REQ-024 Scheduler states:
- IDLE: no RAM access issued.
- RD: display read issued.
- WR: FIFO head written.
REQ-025 Next state, evaluated every cycle:
- disp_req_i=1 -> RD.
- else FIFO non-empty -> WR.
- else -> IDLE.
REQ-026 RD: registered mem_en_o=1, mem_we_o=0, mem_addr_o=disp_addr_i, one cycle after the request.
REQ-027 WR: registered mem_en_o=1, mem_we_o=1, mem_addr_o/mem_wdata_o = FIFO head; the FIFO pops in the cycle the state is selected.
REQ-028 IDLE: mem_en_o=0 and mem_we_o=0; mem_addr_o and mem_wdata_o hold their previous values.
REQ-029 Read latency is fixed at 3 cycles: request at cycle t -> disp_vld_o=1 and disp_data_o=registered mem_rdata_i at t+3.
REQ-030 Back-to-back requests shall produce back-to-back disp_vld_o pulses in request order; there are no bubbles.
REQ-031 Simultaneous push and pop on a full FIFO is not possible, because ready is low when full.
REQ-032 Simultaneous push and pop on a non-empty, non-full FIFO shall leave the level unchanged.
REQ-033 Push into an empty FIFO: the entry is eligible for popping from the next cycle (no fall-through).
REQ-034 Host writes shall reach the RAM in acceptance order.
REQ-035 Pointers shall wrap modulo FIFO_DEPTH; level shall saturate neither up nor down in legal use.
REQ-036 ovf_o shall set on any cycle with host_valid_i=1 and host_ready_o=0, and clear only on reset.
REQ-037 Read-after-write to the same address: a display read issued after the WR cycle shall return the new data.

Reset
REQ-038 Asserting rst_n_i low shall immediately force the following:
- state = IDLE
- mem_en_o=0, mem_we_o=0, mem_addr_o=0, mem_wdata_o=0
- disp_vld_o=0, disp_data_o=0
- FIFO empty, fifo_level_o=0, host_ready_o=1
- ovf_o=0
REQ-039 Reset asserted mid-operation shall discard in-flight reads and pending FIFO entries; no partial write shall be issued after deassertion.
REQ-040 The first cycle after deassertion shall follow REQ-025 normally.

Structure
REQ-041 A shared package vga_pkg shall hold the state enumeration (IDLE/RD/WR) and default widths FB_ADDR_W=16 and PIX_W=12.
REQ-042 The host FIFO shall be the sub-module sync_fifo, with parameters WIDTH=ADDR_W+DATA_W and DEPTH=FIFO_DEPTH, and ports push, pop, full, empty and level.
REQ-043 The read-valid pipeline shall be a 3-stage shift register inside the top module.

Verification
REQ-044 Reset, then one read: preload RAM[0x0010]=0xABC, pulse disp_req_i with addr 0x0010 at t -> disp_vld_o=1, disp_data_o=0xABC at t+3 only.
REQ-045 Continuous reads for 640 cycles with host_valid_i=1: exactly 4 writes are accepted, host_ready_o=0 afterwards, ovf_o=1, and mem_we_o is never 1 during the reads.
REQ-046 Host burst of 6 writes (addr 0..5, data 0x100..0x105) with no display traffic: RAM holds all six in order, fifo_level_o returns to 0, and ovf_o stays 0.
REQ-047 Write 0x7E7 to addr 0x0020, then read 0x0020 on the cycle after the WR state -> disp_data_o=0x7E7.
REQ-048 Fill the FIFO with 3 entries, assert rst_n_i low mid-read for 1 cycle -> all outputs at reset values asynchronously, and no mem_we_o pulse after release.
REQ-049 Interleaved traffic (display requests on alternate cycles, host always valid): every read returns correct data at +3, and writes drain in the gaps.
